lbm_noise_inject: RTL and testbench

Downstream consumer of the 56-bit Gaussian noise generator in the fluctuating-LBM datapath. Buffers generator samples in a small FIFO, converts each to a centred, scaled 16-bit signed noise term, and adds it with saturation to a stream of distribution values `f_in` under valid/ready handshake. Sits between the collision stage (upstream of `f_in`) and the streaming/writeback stage (downstream of `f_out`). Emits a one-cycle `frame_done` pulse every `NODES` injected values.

---
 rtl/lbm_noise_inject.sv | 124 ++++++++++++
 tb/tb_lbm_noise_inject.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lbm_noise_inject.sv
// Noise injection stage for the fluctuating-LBM datapath: buffers Gaussian generator
// samples, centres and scales them, and adds them with saturation to the f_in stream.
module lbm_noise_inject #(
  parameter int DEPTH = 4,
  parameter int SHIFT = 4,
  parameter int NODES = 64
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [55:0]               gen_sample,
  input  logic                      gen_valid,
  input  logic                      inject_en,
  input  logic signed [15:0]        f_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [15:0]        f_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (NODES > 1) ? $clog2(NODES) : 1;

  // Offset-binary top 16 bits become a centred two's-complement value, then scaled down.
  function automatic logic signed [15:0] to_noise(input logic [15:0] top);
    logic signed [15:0] raw;
    raw = {~top[15], top[14:0]};
    return raw >>> SHIFT;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic signed [15:0] f_out_q, f_out_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               acc, pop, push;
  logic signed [15:0] head, addend, noise_in;
  logic signed [16:0] sum;
  logic               unused_gen_lo;

  assign unused_gen_lo = ^gen_sample[39:0];

  always_comb begin
    head         = mem_q[rd_ptr_q];
    noise_in     = to_noise(gen_sample[55:40]);
    in_ready     = (!out_valid_q || out_ready) && (inject_en ? (level_q != '0) : 1'b1);
    acc          = in_valid && in_ready;
    pop          = acc && inject_en;
    push         = gen_valid && ((level_q < LW'(DEPTH)) || pop);
    addend       = inject_en ? head : 16'sd0;
    sum          = {f_in[15], f_in} + {addend[15], addend};

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    f_out_d      = f_out_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (acc) begin
      f_out_d     = sat16(sum);
      out_valid_d = 1'b1;
      if (cnt_q == CW'(NODES - 1)) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage boundary: result, FIFO pointers and frame state registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      f_out_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      f_out_q      <= f_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Reset) mem_q[wr_ptr_q] <= noise_in;
  end

  assign f_out      = f_out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_lbm_noise_inject.sv
// Randomized and directed scoreboard bench for lbm_noise_inject (DEPTH=4, SHIFT=4, NODES=8).
module tb_lbm_noise_inject;
  localparam int DEPTH = 4;
  localparam int SHIFT = 4;
  localparam int NODES = 8;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic [55:0]        gen_sample = '0;
  logic               gen_valid = 1'b0;
  logic               inject_en = 1'b0;
  logic signed [15:0] f_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] f_out;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               frame_done;
  logic [2:0]         fifo_level;

  lbm_noise_inject #(.DEPTH(DEPTH), .SHIFT(SHIFT), .NODES(NODES)) dut (
    .Clk(Clk), .Reset(Reset), .gen_sample(gen_sample), .gen_valid(gen_valid),
    .inject_en(inject_en), .f_in(f_in), .in_valid(in_valid), .in_ready(in_ready),
    .f_out(f_out), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .fifo_level(fifo_level)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference state: noise values waiting in the FIFO, expected outputs, handshake/frame state.
  int nq[$];
  int exp_q[$];
  bit m_ov = 0;
  bit m_fd = 0;
  int m_cnt = 0;
  int m_fout = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int noise_of(input logic [15:0] top);
    int n;
    n = int'(top) - 32768;
    return n >>> SHIFT;
  endfunction

  function automatic int clamp(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got f_out=%0d with no pending expected value", f_out);
      end else begin
        chk("f_out_data", int'(f_out), exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit gv, input logic [55:0] gs, input bit inj, input int fin,
                      input bit iv, input bit ordy);
    bit rdy, acc, pop, push, fd_next;
    int s;
    @(posedge Clk);
    #2;
    gen_valid = gv; gen_sample = gs; inject_en = inj;
    f_in = 16'(fin); in_valid = iv; out_ready = ordy;
    #1;
    rdy = (!m_ov || ordy) && (inj ? (nq.size() != 0) : 1'b1);
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("fifo_level", int'(fifo_level), nq.size());
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("frame_done", int'(frame_done), int'(m_fd));
    if (m_ov) chk("f_out_hold", int'(f_out), m_fout);
    acc = iv && rdy;
    pop = acc && inj;
    push = gv && ((nq.size() < DEPTH) || pop);
    fd_next = 0;
    if (acc) begin
      s = fin;
      if (pop) s = s + nq.pop_front();
      s = clamp(s);
      exp_q.push_back(s);
      m_fout = s;
      m_cnt++;
      if (m_cnt == NODES) begin
        m_cnt = 0;
        fd_next = 1;
      end
    end
    if (push) nq.push_back(noise_of(gs[55:40]));
    m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
    m_fd = fd_next;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    Reset = 1'b1; gen_valid = 1'b1; in_valid = 1'b1; inject_en = 1'b1; out_ready = 1'b0;
    f_in = 16'sd1234;
    @(posedge Clk);
    #2;
    Reset = 1'b0; gen_valid = 1'b0; in_valid = 1'b0;
    nq.delete(); exp_q.delete();
    m_ov = 0; m_fd = 0; m_cnt = 0; m_fout = 0;
    #1;
    chk("rst_f_out", int'(f_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
  endtask

  function automatic logic [55:0] mk(input logic [15:0] top);
    logic [7:0]  hi;
    logic [31:0] lo;
    hi = 8'($urandom);
    lo = $urandom;
    return {top, hi, lo};
  endfunction

  initial begin
    logic signed [15:0] r;
    do_reset();

    // Centre/scale: 0x8010 -> +1, then f_in=100 gives 101; first cycle after reset not ready.
    step(1, mk(16'h8010), 1, 0, 0, 1);
    step(0, mk(16'h0000), 1, 100, 1, 1);
    step(0, mk(16'h0000), 1, 0, 0, 1);

    // Saturation at both rails.
    step(1, mk(16'hFFFF), 1, 0, 0, 1);
    step(1, mk(16'h0000), 1, 32000, 1, 1);
    step(0, mk(16'h0000), 1, -32000, 1, 1);
    step(0, mk(16'h0000), 1, 0, 0, 1);

    // Backpressure: fill, then out_ready=0 for 5 cycles with in_valid held.
    for (int i = 0; i < 4; i++) step(1, mk(16'(16'h7000 + 16'(i * 256))), 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, mk(16'h0), 1, 500 + i, 1, 0);
    for (int i = 0; i < 4; i++) step(0, mk(16'h0), 1, 600 + i, 1, 1);
    step(0, mk(16'h0), 1, 0, 0, 1);

    // FIFO boundary: drain to empty, single push, then push+pop at full.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, mk(16'(16'h9000 + 16'(i))), 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, mk(16'h0), 1, -10 * i, 1, 1);
    step(0, mk(16'h0), 1, 7, 1, 1);
    step(1, mk(16'hA5A5), 1, 0, 0, 1);
    step(0, mk(16'h0), 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, mk(16'(16'h4000 + 16'(i))), 1, 0, 0, 1);
    step(1, mk(16'hC000), 1, 33, 1, 1);
    step(0, mk(16'h0), 1, 0, 0, 1);

    // Bypass and frame: alternating inject_en over one frame of 8 accepts.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, mk(16'(16'h8100 + 16'(i * 16))), 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, mk(16'h0), (i % 2) == 0, 1000 + i, 1, 1);
    for (int i = 0; i < 2; i++) step(0, mk(16'h0), 0, 0, 0, 1);

    // Reset mid-stream with out_valid=1 and fifo_level=3, then a full bypass frame.
    for (int i = 0; i < 4; i++) step(1, mk(16'h8800), 1, 0, 0, 1);
    step(0, mk(16'h0), 1, 42, 1, 0);
    step(0, mk(16'h0), 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, mk(16'h8000), 0, -i, 1, 1);
    step(0, mk(16'h0), 0, 0, 0, 1);
    step(0, mk(16'h0), 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      step($urandom_range(0, 2) != 0, {24'($urandom), $urandom}, $urandom_range(0, 3) != 0,
           int'(r), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) step(0, mk(16'h0), 0, 0, 0, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
